// File: rtl/cr_rbus_pkg.sv
// rtl/cr_rbus_pkg.sv - shared rbus ring types: ring bundle, response status, master FSM states
//
// rbus_ring_t : one ring hop. addr/wr_data/strobes travel forward from the
//               initiator; rd_data/ack/err_ack are filled in by the addressed
//               responder and travel on to the ring end.
package cr_rbus_pkg;

    localparam int RBUS_ADDR_W = 16;
    localparam int RBUS_DATA_W = 32;

    typedef struct packed {
        logic [RBUS_ADDR_W-1:0] addr;
        logic [RBUS_DATA_W-1:0] wr_data;
        logic [RBUS_DATA_W-1:0] rd_data;
        logic                   wr_strb;
        logic                   rd_strb;
        logic                   ack;
        logic                   err_ack;
    } rbus_ring_t;

    typedef enum logic [1:0] {
        RBUS_OK      = 2'b00,
        RBUS_ERR     = 2'b01,
        RBUS_TIMEOUT = 2'b10
    } rbus_rsp_status_e;

    typedef enum logic [1:0] {
        MST_IDLE  = 2'd0,
        MST_ISSUE = 2'd1,
        MST_WAIT  = 2'd2,
        MST_RESP  = 2'd3
    } rbus_mst_state_e;

endpackage

// File: rtl/nx_sat_counter.sv
// rtl/nx_sat_counter.sv - W-bit counter that increments on inc and sticks at all-ones
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (count clears to 0)
//   inc        : increment request for this cycle
//   count      : current value, saturates at 2**W-1
module nx_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cr_rbus_ring_master.sv
// rtl/cr_rbus_ring_master.sv - rbus ring initiator: one outstanding register read/write with timeout
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_ready : command handshake; req_wr, req_addr, req_wr_data carry the command
//   rsp_valid/rsp_ready : response handshake; rsp_rd_data, rsp_status (00 ok, 01 err, 10 timeout)
//   cfg_timeout         : wait-cycle limit, 0 = wait forever
//   rbus_ring_o         : ring launch toward the first responder
//   rbus_ring_i         : ring return from the last responder (terminates here)
//   busy                : not idle
//   stray_ack_cnt       : saturating count of ack/err_ack seen outside WAIT
module cr_rbus_ring_master
    import cr_rbus_pkg::*;
#(
    parameter int N_RBUS_ADDR_BITS = RBUS_ADDR_W,
    parameter int N_RBUS_DATA_BITS = RBUS_DATA_W,
    parameter int TIMEOUT_W        = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_wr,
    input  logic [N_RBUS_ADDR_BITS-1:0] req_addr,
    input  logic [N_RBUS_DATA_BITS-1:0] req_wr_data,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [N_RBUS_DATA_BITS-1:0] rsp_rd_data,
    output logic [1:0]                  rsp_status,
    input  logic [TIMEOUT_W-1:0]        cfg_timeout,
    output rbus_ring_t                  rbus_ring_o,
    input  rbus_ring_t                  rbus_ring_i,
    output logic                        busy,
    output logic [7:0]                  stray_ack_cnt
);

    rbus_mst_state_e state_q, state_d;

    // Holds req_ready low until the first clock after reset release so that
    // every output reads 0 while rst_n is asserted.
    logic                        run_q;
    logic                        cmd_wr_q;
    logic [N_RBUS_ADDR_BITS-1:0] o_addr_q;
    logic [N_RBUS_DATA_BITS-1:0] o_wr_data_q;
    logic                        o_wr_strb_q;
    logic                        o_rd_strb_q;
    logic [TIMEOUT_W-1:0]        wait_cnt_q;
    logic [TIMEOUT_W-1:0]        wait_cnt_inc;
    logic [N_RBUS_DATA_BITS-1:0] rsp_rd_data_q;
    rbus_rsp_status_e            rsp_status_q;

    logic accept;
    logic rsp_seen;
    logic tmo_hit;
    logic stray_evt;

    assign rsp_seen     = rbus_ring_i.ack || rbus_ring_i.err_ack;
    assign wait_cnt_inc = wait_cnt_q + TIMEOUT_W'(1);

    // wait_cnt_q holds (WAIT cycle number - 1), so the increment equals the
    // current WAIT cycle number: the timeout fires in WAIT cycle cfg_timeout.
    assign tmo_hit = (cfg_timeout != '0) && (wait_cnt_inc == cfg_timeout);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        accept    = 1'b0;
        stray_evt = rsp_seen;
        case (state_q)
            MST_IDLE: begin
                busy      = 1'b0;
                req_ready = run_q;
                accept    = req_valid && run_q;
                if (accept) begin
                    state_d = MST_ISSUE;
                end
            end
            MST_ISSUE: begin
                state_d = MST_WAIT;
            end
            MST_WAIT: begin
                stray_evt = 1'b0;
                if (rsp_seen || tmo_hit) begin
                    state_d = MST_RESP;
                end
            end
            MST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = MST_IDLE;
                end
            end
            default: begin
                state_d = MST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q         <= 1'b0;
            cmd_wr_q      <= 1'b0;
            o_addr_q      <= '0;
            o_wr_data_q   <= '0;
            o_wr_strb_q   <= 1'b0;
            o_rd_strb_q   <= 1'b0;
            wait_cnt_q    <= '0;
            rsp_rd_data_q <= '0;
            rsp_status_q  <= RBUS_OK;
        end else begin
            run_q <= 1'b1;
            case (state_q)
                MST_IDLE: begin
                    if (accept) begin
                        cmd_wr_q    <= req_wr;
                        o_addr_q    <= req_addr;
                        o_wr_data_q <= req_wr_data;
                        o_wr_strb_q <= req_wr;
                        o_rd_strb_q <= !req_wr;
                    end
                end
                MST_ISSUE: begin
                    o_wr_strb_q <= 1'b0;
                    o_rd_strb_q <= 1'b0;
                    wait_cnt_q  <= '0;
                end
                MST_WAIT: begin
                    wait_cnt_q <= wait_cnt_inc;
                    // A response in the timeout cycle takes priority.
                    if (rsp_seen) begin
                        rsp_status_q  <= rbus_ring_i.err_ack ? RBUS_ERR : RBUS_OK;
                        rsp_rd_data_q <= (rbus_ring_i.err_ack || cmd_wr_q) ?
                                         '0 : rbus_ring_i.rd_data;
                    end else if (tmo_hit) begin
                        rsp_status_q  <= RBUS_TIMEOUT;
                        rsp_rd_data_q <= '0;
                    end
                end
                MST_RESP: begin
                    if (rsp_ready) begin
                        o_addr_q    <= '0;
                        o_wr_data_q <= '0;
                    end
                end
                default: begin
                    o_wr_strb_q <= 1'b0;
                    o_rd_strb_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        rbus_ring_o         = '0;
        rbus_ring_o.addr    = o_addr_q;
        rbus_ring_o.wr_data = o_wr_data_q;
        rbus_ring_o.wr_strb = o_wr_strb_q;
        rbus_ring_o.rd_strb = o_rd_strb_q;
    end

    assign rsp_rd_data = rsp_rd_data_q;
    assign rsp_status  = rsp_status_q;

    // Forward-path fields of the return ring carry nothing for the origin.
    logic unused_ring_i;
    assign unused_ring_i = ^{rbus_ring_i.addr, rbus_ring_i.wr_data,
                             rbus_ring_i.wr_strb, rbus_ring_i.rd_strb};

    nx_sat_counter #(
        .W (8)
    ) u_stray_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stray_evt),
        .count (stray_ack_cnt)
    );

endmodule

// File: tb/tb_cr_rbus_ring_master.sv
// tb/tb_cr_rbus_ring_master.sv - self-checking bench for cr_rbus_ring_master
module tb_cr_rbus_ring_master;
    import cr_rbus_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wr = 1'b0;
    logic [15:0] req_addr = '0;
    logic [31:0] req_wr_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rd_data;
    logic [1:0]  rsp_status;
    logic [15:0] cfg_timeout = '0;
    rbus_ring_t  ring_o;
    rbus_ring_t  ring_i = '0;
    logic        busy;
    logic [7:0]  stray_ack_cnt;

    int checks = 0;
    int errors = 0;
    int exp_stray = 0;

    always #5 clk = ~clk;

    cr_rbus_ring_master dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_wr        (req_wr),
        .req_addr      (req_addr),
        .req_wr_data   (req_wr_data),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rd_data   (rsp_rd_data),
        .rsp_status    (rsp_status),
        .cfg_timeout   (cfg_timeout),
        .rbus_ring_o   (ring_o),
        .rbus_ring_i   (ring_i),
        .busy          (busy),
        .stray_ack_cnt (stray_ack_cnt)
    );

    // kind: bit0 = ack, bit1 = err_ack, 0 = responder silent
    // lat : ack arrives lat cycles after the strobe cycle (WAIT cycle lat)
    // exp_lat: cycles from accept edge to first rsp_valid
    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
        int          kind;
        int          cfg;
        int          hold;
        int          exp_lat;
        logic [1:0]  exp_status;
        logic [31:0] exp_data;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: a response lands in time if the responder answers and either
    // no timeout is set or the answer comes no later than WAIT cycle cfg.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        if ((v.kind != 0) && ((v.cfg == 0) || (v.lat <= v.cfg))) begin
            r.exp_lat    = 2 + v.lat;
            r.exp_status = ((v.kind & 2) != 0) ? 2'b01 : 2'b00;
            r.exp_data   = (r.exp_status == 2'b00 && !v.wr) ? v.rdata : 32'h0;
        end else begin
            r.exp_lat    = 2 + v.cfg;
            r.exp_status = 2'b10;
            r.exp_data   = 32'h0;
        end
        return r;
    endfunction

    task automatic do_txn(input vec_t v);
        int n;
        int got;
        cfg_timeout = 16'(v.cfg);
        req_wr      = v.wr;
        req_addr    = v.addr;
        req_wr_data = v.wdata;
        req_valid   = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        chk("req_ready_wait", req_ready, 1'b1);
        tick();
        req_valid = 1'b0;
        got = 0;
        for (int k = 1; k <= v.exp_lat + 4 && got == 0; k++) begin
            if (k == 1) begin
                chk("wr_strb", ring_o.wr_strb, v.wr);
                chk("rd_strb", ring_o.rd_strb, !v.wr);
                chk("issue_addr", ring_o.addr, v.addr);
                chk("issue_wdata", ring_o.wr_data, v.wdata);
                chk("busy_issue", busy, 1'b1);
            end
            if (k == 2) begin
                chk("strb_pulse", {ring_o.wr_strb, ring_o.rd_strb}, 2'b00);
                chk("wait_addr_hold", ring_o.addr, v.addr);
            end
            if (rsp_valid) begin
                got = k;
            end else begin
                ring_i.ack     = ((v.kind & 1) != 0) && (k == 1 + v.lat);
                ring_i.err_ack = ((v.kind & 2) != 0) && (k == 1 + v.lat);
                ring_i.rd_data = v.rdata;
                tick();
            end
        end
        ring_i = '0;
        if (got == 0) begin
            chk("rsp_valid_bound", 1'b0, 1'b1);
        end else begin
            chk("rsp_lat", 64'(got), 64'(v.exp_lat));
            chk("rsp_status", rsp_status, v.exp_status);
            chk("rsp_rd_data", rsp_rd_data, v.exp_data);
            for (int h = 0; h < v.hold; h++) begin
                tick();
                chk("hold_stable", {rsp_valid, req_ready, rsp_status, rsp_rd_data},
                    {1'b1, 1'b0, v.exp_status, v.exp_data});
            end
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
            chk("rsp_drop", {rsp_valid, busy}, 2'b00);
            chk("idle_addr_zero", ring_o.addr, 16'h0);
        end
    endtask

    vec_t tbl[8];
    vec_t rv;

    initial begin
        //            wr    addr      wdata         rdata         lat   kind cfg hold exp_lat st     data
        tbl[0] = '{1'b0, 16'h0010, 32'h0,        32'hDEADBEEF, 3,    1,   0,  0,   5,      2'b00, 32'hDEADBEEF};
        tbl[1] = '{1'b1, 16'h0024, 32'h12345678, 32'hA5A5A5A5, 2,    2,   20, 0,   4,      2'b01, 32'h0};
        tbl[2] = '{1'b0, 16'h0030, 32'h0,        32'h11111111, 1,    0,   5,  0,   7,      2'b10, 32'h0};
        tbl[3] = '{1'b0, 16'h0040, 32'h0,        32'hCAFEF00D, 5,    1,   5,  0,   7,      2'b00, 32'hCAFEF00D};
        tbl[4] = '{1'b0, 16'h0044, 32'h0,        32'h01020304, 1000, 1,   0,  0,   1002,   2'b00, 32'h01020304};
        tbl[5] = '{1'b0, 16'h0048, 32'h0,        32'h00000055, 1,    3,   4,  10,  3,      2'b01, 32'h0};
        tbl[6] = '{1'b1, 16'h004C, 32'h9ABCDEF0, 32'h0,        6,    1,   5,  0,   7,      2'b10, 32'h0};
        tbl[7] = '{1'b1, 16'h0050, 32'h0BADF00D, 32'hFFFFFFFF, 1,    1,   1,  10,  3,      2'b00, 32'h0};

        tick();
        tick();
        chk("reset_outputs", {req_ready, rsp_valid, busy, stray_ack_cnt, rsp_status, rsp_rd_data},
            {1'b0, 1'b0, 1'b0, 8'h0, 2'b00, 32'h0});
        chk("reset_ring_o", ring_o, '0);
        rst_n = 1'b1;
        tick();
        chk("ready_after_reset", req_ready, 1'b1);

        for (int i = 0; i < 8; i++) begin
            do_txn(tbl[i]);
        end
        chk("no_stray_table", stray_ack_cnt, 8'(exp_stray));

        // Late ack after a timeout counts as stray and produces no response.
        do_txn(tbl[2]);
        tick();
        ring_i.ack = 1'b1;
        tick();
        ring_i.ack = 1'b0;
        exp_stray++;
        chk("stray_after_timeout", stray_ack_cnt, 8'(exp_stray));
        chk("stray_no_rsp", rsp_valid, 1'b0);
        tick();
        chk("stray_no_rsp2", {rsp_valid, busy}, 2'b00);

        for (int i = 0; i < 300; i++) begin
            ring_i.err_ack = i[0];
            ring_i.ack     = !i[0];
            tick();
            ring_i = '0;
            tick();
        end
        chk("stray_saturate", stray_ack_cnt, 8'd255);

        // Reset during WAIT aborts the transaction.
        cfg_timeout = 16'd0;
        req_wr      = 1'b0;
        req_addr    = 16'h0060;
        req_valid   = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        chk("busy_in_wait", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midreset_outputs", {req_ready, rsp_valid, busy, stray_ack_cnt, rsp_status, rsp_rd_data},
            {1'b0, 1'b0, 1'b0, 8'h0, 2'b00, 32'h0});
        chk("midreset_ring_o", ring_o, '0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_reset_quiet", {busy, rsp_valid, ring_o.rd_strb, ring_o.wr_strb}, 4'b0000);
        ring_i.ack = 1'b1;
        tick();
        ring_i.ack = 1'b0;
        tick();
        exp_stray = 1;
        chk("aborted_ack_stray", stray_ack_cnt, 8'(exp_stray));
        chk("aborted_no_rsp", rsp_valid, 1'b0);
        rv = '{1'b0, 16'h0064, 32'h0, 32'h76543210, 2, 1, 8, 0, 0, 2'b00, 32'h0};
        do_txn(model(rv));

        for (int i = 0; i < 40; i++) begin
            rv.wr    = 1'($urandom_range(0, 1));
            rv.addr  = 16'($urandom);
            rv.wdata = $urandom;
            rv.rdata = $urandom;
            rv.kind  = int'($urandom_range(0, 3));
            rv.lat   = int'($urandom_range(1, 10));
            rv.cfg   = int'($urandom_range(0, 8));
            if (rv.kind == 0 && rv.cfg == 0) rv.cfg = 3;
            rv.hold  = int'($urandom_range(0, 3));
            do_txn(model(rv));
        end
        chk("stray_final", stray_ack_cnt, 8'(exp_stray));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cr_rbus_ring_master.md
# cr_rbus_ring_master

Ring initiator for the rbus register ring: accepts single register read/write commands from a local requester (debug/config host port) and launches them onto the ring. It waits for the addressed responder's ack/err_ack returning on the ring input, or times out, then returns read data and status to the requester. It sits at the ring origin; the ring input terminates here. One transaction is outstanding at a time.

## Interface
- N_RBUS_ADDR_BITS, default `N_RBUS_ADDR_BITS: ring address width.
- N_RBUS_DATA_BITS, default `N_RBUS_DATA_BITS (32): ring data width.
- TIMEOUT_W, default 16: width of the timeout configuration and wait counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  command valid.
- req_ready  out  1  command accepted when req_valid && req_ready.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  N_RBUS_ADDR_BITS  register address.
- req_wr_data  in  N_RBUS_DATA_BITS  write data.
- rsp_valid  out  1  response valid, held until rsp_ready.
- rsp_ready  in  1  response consumed.
- rsp_rd_data  out  N_RBUS_DATA_BITS  read data; 0 for writes, errors and timeouts.
- rsp_status  out  2  00 ok, 01 err_ack, 10 timeout.
- cfg_timeout  in  TIMEOUT_W  maximum wait cycles; 0 disables the timeout.
- rbus_ring_o  out  rbus_ring_t  ring output toward the first responder.
- rbus_ring_i  in  rbus_ring_t  ring return from the last responder.
- busy  out  1  high in any state other than IDLE.
- stray_ack_cnt  out  8  saturating count of unexpected ack/err_ack pulses.

## Operation
- State machine with four states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On accept, register req_wr, req_addr and req_wr_data, then go to ISSUE.
- ISSUE (exactly 1 cycle):
  - Drive rbus_ring_o.addr and wr_data from the registered command.
  - Drive rbus_ring_o.wr_strb = req_wr or rd_strb = !req_wr as a single-cycle pulse.
  - Clear the wait counter, then go to WAIT.
- WAIT:
  - addr and wr_data are held, strobes are 0, and the counter increments every cycle.
  - Response: rbus_ring_i.ack or err_ack sampled high.
    - ack only: status 00, rd_data = rbus_ring_i.rd_data for reads.
    - err_ack, or ack and err_ack together: status 01.
    - Go to RESP.
  - Timeout: counter reaches cfg_timeout (cfg_timeout != 0) with no response, i.e. no response in WAIT cycles 1..cfg_timeout. Status 10, go to RESP.
  - A response arriving in the same cycle the timeout fires wins; status is 00 or 01.
- RESP:
  - rsp_valid = 1 with data and status stable.
  - On rsp_ready, go to IDLE.
  - The next command is accepted no earlier than the cycle after rsp_valid drops.
- Stray responses:
  - An ack/err_ack pulse seen in IDLE, ISSUE or RESP (including late responses after a timeout) increments stray_ack_cnt.
  - stray_ack_cnt saturates at 255 and is never delivered to the requester.
- Ring output:
  - rbus_ring_o.rd_data, ack and err_ack are always 0; the master originates the ring.
  - addr and wr_data are 0 in IDLE.
- Reset: all outputs 0, stray_ack_cnt 0, state IDLE.
  - Reset asserted mid-transaction aborts it; no strobe or response is produced afterwards.
  - A later response from the aborted transaction counts as stray.

## Timing
- Command accepted at cycle T: strobe on rbus_ring_o at T+1 (registered output).
- Response sampled at cycle R (R ≥ T+2): rsp_valid at R+1.
- Timeout: rsp_valid at T+2+cfg_timeout.
- Best-case command-to-next-command throughput is 4 cycles: IDLE, ISSUE, WAIT with immediate ack, RESP with rsp_ready already high.
- rsp_rd_data and rsp_status are registered; they change only on entry to RESP.

## Structure
- Shared package (cr_rbus_pkg): rbus_ring_t (existing), rbus_rsp_status_e {RBUS_OK, RBUS_ERR, RBUS_TIMEOUT}, and the state enum rbus_mst_state_e.
- One natural sub-module: nx_sat_counter (8-bit saturating increment) for stray_ack_cnt.
- The wait counter stays inline.

## Test plan
- Read 0x0010 with the responder acking 3 cycles after the strobe and rd_data=0xDEADBEEF:
  - rd_strb is a 1-cycle pulse at T+1.
  - rsp_valid has status 00 and data 0xDEADBEEF.
- Write 0x0024 with data 0x12345678 and the responder returning err_ack:
  - wr_strb pulses with wr_data=0x12345678.
  - rsp_status 01, rsp_rd_data 0.
- Read with cfg_timeout=5 and no responder:
  - rsp_valid at T+7, status 10.
  - An ack injected 2 cycles later raises stray_ack_cnt to 1 and produces no rsp_valid.
- Ack arriving in exactly WAIT cycle 5 with cfg_timeout=5 → status 00.
- Same transaction with cfg_timeout=0 and an ack after 1000 cycles → status 00, no timeout.
- rsp_ready held low for 10 cycles:
  - rsp_valid, data and status stay stable and req_ready stays 0.
  - 300 stray acks in IDLE saturate stray_ack_cnt at 255.
- Assert rst_n during WAIT:
  - All outputs go to 0 and the state goes to IDLE.
  - The next read completes normally.
